// File: rtl/loader_pkg.sv
// Shared encodings for the boot-time instruction loader and its UART receiver.
package loader_pkg;

    typedef enum logic [2:0] {
        ST_SYNC,
        ST_LEN,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } ld_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    localparam logic [7:0] SYNC_BYTE      = 8'hA5;
    localparam int         BYTES_PER_WORD = 4;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: one-cycle byte_valid with byte_data/frame_err, just after the stop-bit
// midpoint plus synchronizer delay. No backpressure: each byte is presented once.
module uart_rx
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clock,
    input  logic       clear,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

    logic            rx_s1_q, rx_s2_q, rx_s3_q;
    rx_state_e       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            valid_q, valid_d;
    logic            ferr_q, ferr_d;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
            rx_s3_q <= 1'b1;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            rx_s1_q <= rx;
            rx_s2_q <= rx_s1_q;
            rx_s3_q <= rx_s2_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        ferr_d  = ferr_q;
        case (state_q)
            RX_IDLE: begin
                // Edge (not level) detect so a low line after a bad stop bit cannot re-trigger
                if (rx_s3_q && !rx_s2_q) begin
                    state_d = RX_START;
                    cnt_d   = '0;
                end
            end
            RX_START: begin
                if (cnt_q == HALF) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_s2_q ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL) begin
                    cnt_d   = '0;
                    shift_d = {rx_s2_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = RX_STOP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL) begin
                    cnt_d   = '0;
                    valid_d = 1'b1;
                    ferr_d  = !rx_s2_q;
                    state_d = RX_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign byte_valid = valid_q;
    assign byte_data  = shift_q;
    assign frame_err  = ferr_q;

endmodule

// File: rtl/imem_loader.sv
// Loads a checksummed UART program image into IRAM and releases the core once verified.
// Write strobe one cycle after a word's 4th byte; status one cycle after the deciding byte. No backpressure.
module imem_loader
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int ADDR_WIDTH   = 8
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  rx,
    output logic [ADDR_WIDTH-1:0] iram_addr,
    output logic [31:0]           iram_data,
    output logic                  iram_wren,
    output logic                  core_clear,
    output logic                  done,
    output logic                  error
);

    localparam int AW = ADDR_WIDTH;

    logic       byte_valid;
    logic [7:0] byte_data;
    logic       frame_err;

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clock      (clock),
        .clear      (clear),
        .rx         (rx),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_err  (frame_err)
    );

    ld_state_e      state_q, state_d;
    logic [AW-1:0]  len_q, len_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [1:0]     byte_cnt_q, byte_cnt_d;
    logic [7:0]     csum_q, csum_d;
    logic [31:0]    data_q, data_d;
    logic           wren_q, wren_d;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q    <= ST_SYNC;
            len_q      <= '0;
            addr_q     <= '0;
            byte_cnt_q <= '0;
            csum_q     <= '0;
            data_q     <= '0;
            wren_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            addr_q     <= addr_d;
            byte_cnt_q <= byte_cnt_d;
            csum_q     <= csum_d;
            data_q     <= data_d;
            wren_q     <= wren_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        addr_d     = addr_q;
        byte_cnt_d = byte_cnt_q;
        csum_d     = csum_q;
        data_d     = data_q;
        wren_d     = 1'b0;
        // Address advances only after the write cycle so it stays stable under the strobe
        if (wren_q) addr_d = addr_q + AW'(1);
        if (byte_valid) begin
            if (frame_err) begin
                if (state_q != ST_DONE) state_d = ST_ERR;
            end else begin
                case (state_q)
                    ST_SYNC: begin
                        if (byte_data == SYNC_BYTE) state_d = ST_LEN;
                    end
                    ST_LEN: begin
                        len_d      = AW'(byte_data);
                        addr_d     = '0;
                        byte_cnt_d = '0;
                        csum_d     = '0;
                        state_d    = ST_DATA;
                    end
                    ST_DATA: begin
                        data_d     = {byte_data, data_q[31:8]};
                        csum_d     = csum_q ^ byte_data;
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'(BYTES_PER_WORD - 1)) begin
                            wren_d = 1'b1;
                            // len 0 wraps to all-ones, giving the full 2^AW-word image
                            if (addr_q == len_q - AW'(1)) state_d = ST_CSUM;
                        end
                    end
                    ST_CSUM: begin
                        state_d = (byte_data == csum_q) ? ST_DONE : ST_ERR;
                    end
                    ST_DONE: begin
                        state_d = ST_DONE;
                    end
                    ST_ERR: begin
                        if (byte_data == SYNC_BYTE) state_d = ST_LEN;
                    end
                    default: state_d = ST_SYNC;
                endcase
            end
        end
    end

    assign iram_addr  = addr_q;
    assign iram_data  = data_q;
    assign iram_wren  = wren_q;
    assign core_clear = (state_q == ST_DONE);
    assign done       = (state_q == ST_DONE);
    assign error      = (state_q == ST_ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Directed + randomized bench for imem_loader; expected IRAM writes and status come from frame contents.
module tb_imem_loader;

    localparam int CPB = 4;
    localparam int AW  = 8;

    logic          clock = 1'b0;
    logic          clear = 1'b0;
    logic          rx    = 1'b1;
    logic [AW-1:0] iram_addr;
    logic [31:0]   iram_data;
    logic          iram_wren;
    logic          core_clear;
    logic          done;
    logic          error;

    imem_loader #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(AW)) dut (
        .clock      (clock),
        .clear      (clear),
        .rx         (rx),
        .iram_addr  (iram_addr),
        .iram_data  (iram_data),
        .iram_wren  (iram_wren),
        .core_clear (core_clear),
        .done       (done),
        .error      (error)
    );

    always #5 clock = ~clock;

    int          n_asserts = 0;
    int          n_fail    = 0;
    logic [7:0]  pay[$];
    logic [7:0]  got_a[$];
    logic [31:0] got_d[$];
    logic        prev_wren = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clock) begin
        if (iram_wren) begin
            got_a.push_back(iram_addr);
            got_d.push_back(iram_data);
            check("wren_one_cycle", 64'(prev_wren), 64'd0);
        end
        prev_wren = iram_wren;
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (CPB) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clock);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge clock);
        rx = 1'b1;
    endtask

    function automatic logic [7:0] xor_pay();
        logic [7:0] x = 8'h00;
        foreach (pay[i]) x ^= pay[i];
        return x;
    endfunction

    // Every completed word k of the current payload must appear once, in order, at address k
    task automatic check_writes(input string tag, input int nw);
        check({tag, "_nwrites"}, 64'(got_a.size()), 64'(nw));
        for (int k = 0; k < nw && k < got_a.size(); k++) begin
            check({tag, "_addr"}, 64'(got_a[k]), 64'(k[AW-1:0]));
            check({tag, "_data"}, 64'(got_d[k]),
                  64'({pay[4*k+3], pay[4*k+2], pay[4*k+1], pay[4*k]}));
        end
        got_a.delete();
        got_d.delete();
    endtask

    task automatic run_frame(input string tag, input int nw, input logic [7:0] csum);
        logic good;
        int   nbits;
        good = (csum == xor_pay());
        nbits = nw;
        send_byte(8'hA5, 1'b1);
        repeat (2) @(negedge clock);
        check({tag, "_err_after_sync"}, 64'(error), 64'd0);
        send_byte(nbits[7:0], 1'b1);
        foreach (pay[i]) send_byte(pay[i], 1'b1);
        send_byte(csum, 1'b1);
        check({tag, "_status_before"}, 64'({done, core_clear, error}), 64'd0);
        repeat (2) @(negedge clock);
        check({tag, "_status_after"}, 64'({done, core_clear, error}), 64'({good, good, !good}));
        check_writes(tag, nw);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clock);
        clear = 1'b0;
        #1;
        check({tag, "_reset_outs"}, 64'({iram_addr, iram_data, iram_wren, core_clear, done, error}), 64'd0);
        repeat (3) @(negedge clock);
        clear = 1'b1;
        repeat (2) @(negedge clock);
        got_a.delete();
        got_d.delete();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         nw;
        logic [7:0] cs;
        logic [7:0] nb;

        // Reset state
        repeat (3) @(negedge clock);
        check("reset_outs", 64'({iram_addr, iram_data, iram_wren, core_clear, done, error}), 64'd0);
        clear = 1'b1;
        repeat (4) @(negedge clock);

        // 1: good 2-word load
        pay = '{8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00};
        run_frame("good", 2, 8'hC1);

        // Further bytes are ignored once done
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b0);
        repeat (3) @(negedge clock);
        check("done_sticky", 64'({done, core_clear, error}), 64'b110);

        // 2: bad checksum, then retry from ERR
        do_reset("bad");
        run_frame("bad_csum", 2, 8'hC0);
        run_frame("retry", 2, 8'hC1);

        // 3: framing error on 3rd payload byte
        do_reset("frm");
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h93, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h50, 1'b0);
        check("frm_err_before", 64'(error), 64'd0);
        repeat (2) @(negedge clock);
        check("frm_status", 64'({done, core_clear, error}), 64'b001);
        repeat (4 * CPB) @(negedge clock);
        check("frm_nwrites", 64'(got_a.size()), 64'd0);

        // 4: N = 0 (256 words), entered via retry from ERR
        pay.delete();
        for (int i = 0; i < 1024; i++) pay.push_back(i[7:0]);
        run_frame("n0", 256, 8'h00);

        // 5: noise and a short glitch before sync
        do_reset("noise");
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h5A, 1'b1);
        repeat (2 * CPB) @(negedge clock);
        rx = 1'b0;
        @(negedge clock);
        rx = 1'b1;
        repeat (3 * CPB) @(negedge clock);
        check("noise_idle", 64'({done, core_clear, error, 7'(got_a.size())}), 64'd0);
        pay = '{8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00};
        run_frame("noise_good", 2, 8'hC1);

        // 6: reset mid-load, then a clean load
        do_reset("mid");
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        for (int i = 0; i < 5; i++) send_byte(pay[i], 1'b1);
        repeat (3) @(negedge clock);
        check("mid_one_write", 64'(got_a.size()), 64'd1);
        check("mid_addr_adv", 64'(iram_addr), 64'd1);
        do_reset("mid_abort");
        run_frame("mid_reload", 2, 8'hC1);

        // Randomized frames: random size, payload, leading noise, good or corrupted checksum
        for (int it = 0; it < 6; it++) begin
            do_reset("rnd");
            for (int j = 0; j < $urandom_range(0, 2); j++) begin
                nb = 8'($urandom_range(0, 255));
                if (nb == 8'hA5) nb = 8'h5A;
                send_byte(nb, 1'b1);
            end
            nw = $urandom_range(1, 6);
            pay.delete();
            for (int j = 0; j < 4 * nw; j++) pay.push_back(8'($urandom_range(0, 255)));
            cs = xor_pay();
            if ($urandom_range(0, 1) == 1) cs ^= 8'($urandom_range(1, 255));
            run_frame("rnd", nw, cs);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
